// File: rtl/window_feeder.sv
// Serial pixel stream to parallel IMG_NB-wide window for 1-D MAC chains.
// Optional zero padding keeps one output window per input pixel.
module window_feeder #(
  parameter int IMG_WIDTH = 16,
  parameter int IMG_NB    = 3,
  parameter int ROW_LEN   = 8,
  parameter int PAD       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IMG_WIDTH-1:0]          pix,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic [IMG_WIDTH*IMG_NB-1:0]   img,
  output logic                          val,
  output logic                          last
);

  localparam int PADW = (PAD != 0) ? (IMG_NB - 1) / 2 : 0;
  localparam int WW   = IMG_WIDTH * IMG_NB;
  localparam int CW   = $clog2(ROW_LEN);
  localparam int FW   = $clog2(IMG_NB + 1);
  localparam int KW   = (PADW > 0) ? $clog2(PADW + 1) : 1;

  typedef enum logic {
    ROW,
    FLUSH
  } state_t;

  state_t               state;
  logic [WW-1:0]        win;
  logic [WW-1:0]        shifted;
  logic [IMG_WIDTH-1:0] shift_in;
  logic [CW-1:0]        col;
  logic [FW-1:0]        fill;
  logic [FW-1:0]        fill_nx;
  logic [KW-1:0]        kcnt;
  logic                 acc;
  logic                 row_end;

  assign pix_ready = (state == ROW) && !rst;
  assign acc       = pix_valid && pix_ready;
  assign row_end   = (col == CW'(ROW_LEN - 1));

  // Flush cycles push zeros in as the newest lane.
  always_comb begin
    shift_in = '0;
    if (state == ROW) shift_in = pix;
    shifted = {shift_in, win[WW-1:IMG_WIDTH]};
    fill_nx = fill;
    if (fill != FW'(IMG_NB)) fill_nx = fill + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ROW;
      win   <= '0;
      col   <= '0;
      fill  <= FW'(PADW);
      kcnt  <= '0;
      img   <= '0;
      val   <= 1'b0;
      last  <= 1'b0;
    end else begin
      val  <= 1'b0;
      last <= 1'b0;
      unique case (state)
        ROW: begin
          if (acc) begin
            win  <= shifted;
            col  <= col + CW'(1);
            fill <= fill_nx;
            if (fill_nx == FW'(IMG_NB)) begin
              val <= 1'b1;
              img <= shifted;
            end
            if (row_end) begin
              if (PADW == 0) begin
                last <= 1'b1;
                win  <= '0;
                col  <= '0;
                fill <= FW'(PADW);
              end else begin
                state <= FLUSH;
                kcnt  <= KW'(PADW);
              end
            end
          end
        end
        FLUSH: begin
          win  <= shifted;
          val  <= 1'b1;
          img  <= shifted;
          kcnt <= kcnt - KW'(1);
          // Restart shares the edge of the final zero shift.
          if (kcnt == KW'(1)) begin
            last  <= 1'b1;
            state <= ROW;
            win   <= '0;
            col   <= '0;
            fill  <= FW'(PADW);
          end
        end
        default: state <= ROW;
      endcase
    end
  end

endmodule

// File: tb/tb_window_feeder.sv
// Scoreboard bench for window_feeder: three configs (3/5/no pad,
// 3/5/pad, 5/6/pad) driven by directed rows.
module tb_window_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic [15:0] pix [3];
  logic        pv  [3];
  logic        rdy [3];
  logic        val [3];
  logic        last[3];
  logic [47:0] img_a;
  logic [47:0] img_b;
  logic [79:0] img_c;
  logic [79:0] img [3];

  assign img[0] = {32'b0, img_a};
  assign img[1] = {32'b0, img_b};
  assign img[2] = img_c;

  window_feeder #(
    .IMG_WIDTH(16), .IMG_NB(3), .ROW_LEN(5), .PAD(0)
  ) u_a (
    .clk(clk), .rst(rst[0]), .pix(pix[0]),
    .pix_valid(pv[0]), .pix_ready(rdy[0]),
    .img(img_a), .val(val[0]), .last(last[0])
  );

  window_feeder #(
    .IMG_WIDTH(16), .IMG_NB(3), .ROW_LEN(5), .PAD(1)
  ) u_b (
    .clk(clk), .rst(rst[1]), .pix(pix[1]),
    .pix_valid(pv[1]), .pix_ready(rdy[1]),
    .img(img_b), .val(val[1]), .last(last[1])
  );

  window_feeder #(
    .IMG_WIDTH(16), .IMG_NB(5), .ROW_LEN(6), .PAD(1)
  ) u_c (
    .clk(clk), .rst(rst[2]), .pix(pix[2]),
    .pix_valid(pv[2]), .pix_ready(rdy[2]),
    .img(img_c), .val(val[2]), .last(last[2])
  );

  typedef struct packed {
    logic [79:0] w;
    logic        l;
  } exp_t;

  exp_t q[3][$];
  int errors = 0;
  int checks = 0;
  int vcnt[3] = '{0, 0, 0};
  int lcnt[3] = '{0, 0, 0};

  task automatic chk(input string nm, input int i,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h want %0h",
               nm, i, act, exp);
    end
  endtask

  function automatic logic [79:0] w5(input int a, input int b,
                                     input int c, input int d,
                                     input int e);
    return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic push(input int i, input logic [79:0] wv,
                      input logic l);
    exp_t e;
    e.w = wv;
    e.l = l;
    q[i].push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int p, input logic ev);
    pix[i] = 16'(p);
    pv[i]  = 1'b1;
    @(negedge clk);
    chk("ready", i, 80'(rdy[i]), 80'(1));
    step();
    pv[i] = 1'b0;
    chk("val_timing", i, 80'(val[i]), 80'(ev));
  endtask

  task automatic idle(input int i, input int n);
    repeat (n) begin
      step();
      chk("idle_val", i, 80'(val[i]), 80'(0));
    end
  endtask

  task automatic flush(input int i, input int n);
    repeat (n) begin
      @(negedge clk);
      chk("flush_ready", i, 80'(rdy[i]), 80'(0));
      step();
      chk("flush_val", i, 80'(val[i]), 80'(1));
    end
  endtask

  // Monitor: every val pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      if (val[i] === 1'b1) begin
        vcnt[i]++;
        if (last[i] === 1'b1) lcnt[i]++;
        chk("unexp_val", i, 80'(q[i].size() == 0), 80'(0));
        if (q[i].size() != 0) begin
          e = q[i].pop_front();
          chk("img", i, img[i], e.w);
          chk("last", i, 80'(last[i]), 80'(e.l));
        end
      end else if (last[i] === 1'b1) begin
        chk("last_wo_val", i, 80'(last[i]), 80'(0));
      end
    end
  end

  initial begin
    int v0;
    int l0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      pv[i]  = 1'b0;
      pix[i] = '0;
    end
    step();
    step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, 80'(rdy[i]), 80'(0));
      chk("rst_val", i, 80'(val[i]), 80'(0));
      chk("rst_last", i, 80'(last[i]), 80'(0));
      chk("rst_img", i, img[i], 80'(0));
    end
    step();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Single row, no padding
    push(0, w5(1, 2, 3, 0, 0), 1'b0);
    push(0, w5(2, 3, 4, 0, 0), 1'b0);
    push(0, w5(3, 4, 5, 0, 0), 1'b1);
    send(0, 1, 1'b0);
    send(0, 2, 1'b0);
    send(0, 3, 1'b1);
    send(0, 4, 1'b1);
    send(0, 5, 1'b1);
    idle(0, 2);

    // Two back-to-back rows
    v0 = vcnt[0];
    l0 = lcnt[0];
    push(0, w5(1, 2, 3, 0, 0), 1'b0);
    push(0, w5(2, 3, 4, 0, 0), 1'b0);
    push(0, w5(3, 4, 5, 0, 0), 1'b1);
    push(0, w5(6, 7, 8, 0, 0), 1'b0);
    push(0, w5(7, 8, 9, 0, 0), 1'b0);
    push(0, w5(8, 9, 10, 0, 0), 1'b1);
    for (int p = 1; p <= 10; p++)
      send(0, p, ((p - 1) % 5) >= 2);
    idle(0, 2);
    chk("two_row_vals", 0, 80'(vcnt[0] - v0), 80'(6));
    chk("two_row_lasts", 0, 80'(lcnt[0] - l0), 80'(2));

    // Gapped valid 1,0,0,1,1,0,1,1
    push(0, w5(1, 2, 3, 0, 0), 1'b0);
    push(0, w5(2, 3, 4, 0, 0), 1'b0);
    push(0, w5(3, 4, 5, 0, 0), 1'b1);
    send(0, 1, 1'b0);
    idle(0, 2);
    send(0, 2, 1'b0);
    send(0, 3, 1'b1);
    idle(0, 1);
    send(0, 4, 1'b1);
    send(0, 5, 1'b1);
    idle(0, 2);

    // Reset mid-row after pixel 2
    send(0, 1, 1'b0);
    send(0, 2, 1'b0);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 0, 80'(rdy[0]), 80'(0));
    step();
    rst[0] = 1'b0;
    chk("midrst_val", 0, 80'(val[0]), 80'(0));
    push(0, w5(7, 8, 9, 0, 0), 1'b0);
    push(0, w5(8, 9, 10, 0, 0), 1'b0);
    push(0, w5(9, 10, 11, 0, 0), 1'b1);
    send(0, 7, 1'b0);
    send(0, 8, 1'b0);
    send(0, 9, 1'b1);
    send(0, 10, 1'b1);
    send(0, 11, 1'b1);
    idle(0, 2);

    // Padded 3-wide, two rows
    push(1, w5(0, 1, 2, 0, 0), 1'b0);
    push(1, w5(1, 2, 3, 0, 0), 1'b0);
    push(1, w5(2, 3, 4, 0, 0), 1'b0);
    push(1, w5(3, 4, 5, 0, 0), 1'b0);
    push(1, w5(4, 5, 0, 0, 0), 1'b1);
    push(1, w5(0, 6, 7, 0, 0), 1'b0);
    push(1, w5(6, 7, 8, 0, 0), 1'b0);
    push(1, w5(7, 8, 9, 0, 0), 1'b0);
    push(1, w5(8, 9, 10, 0, 0), 1'b0);
    push(1, w5(9, 10, 0, 0, 0), 1'b1);
    send(1, 1, 1'b0);
    for (int p = 2; p <= 5; p++) send(1, p, 1'b1);
    flush(1, 1);
    send(1, 6, 1'b0);
    for (int p = 7; p <= 10; p++) send(1, p, 1'b1);
    flush(1, 1);
    idle(1, 2);

    // Padded 5-wide, ROW_LEN 6
    push(2, w5(0, 0, 1, 2, 3), 1'b0);
    push(2, w5(0, 1, 2, 3, 4), 1'b0);
    push(2, w5(1, 2, 3, 4, 5), 1'b0);
    push(2, w5(2, 3, 4, 5, 6), 1'b0);
    push(2, w5(3, 4, 5, 6, 0), 1'b0);
    push(2, w5(4, 5, 6, 0, 0), 1'b1);
    send(2, 1, 1'b0);
    send(2, 2, 1'b0);
    for (int p = 3; p <= 6; p++) send(2, p, 1'b1);
    flush(2, 2);
    @(negedge clk);
    chk("flush_done_ready", 2, 80'(rdy[2]), 80'(1));
    idle(2, 2);

    for (int i = 0; i < 3; i++)
      chk("sb_empty", i, 80'(q[i].size()), 80'(0));
    chk("pad5_vals", 2, 80'(vcnt[2]), 80'(6));
    chk("pad3_vals", 1, 80'(vcnt[1]), 80'(10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
